// File: rtl/gap_requant_streamer.sv
// ---------------------------------------------------------------------------
// gap_requant_streamer
//
// Purpose:
//   Sits after the global-average-pooling stage. When pooling raises finish,
//   walks the pooled per-channel results (one read per cycle, 1-cycle read
//   latency), requantises each to uint8 (multiply, rounding right shift,
//   saturate) and packs LANES channels per beat onto a valid/ready stream
//   that feeds the SE/FC stage. A small beat FIFO decouples the reader from
//   downstream backpressure. Reads are throttled by a credit scheme so that
//   the FIFO can never overflow.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   finish            pooling results ready; rising edge starts a run
//   num_ch/mult/shift run parameters, sampled when the run starts
//   read_pixel_index  channel address presented to the pooling block
//   data_in           pooled value for the address issued last cycle
//   m_valid/m_ready   output stream handshake
//   m_data/m_keep     packed uint8 lanes and lane-valid mask
//   m_last            final beat of the run
//   busy              run in progress
//   done              one-cycle pulse once the last beat is accepted
//
// LANES and FIFO_DEPTH are expected to be powers of two, LANES >= 2.
// ---------------------------------------------------------------------------
module gap_requant_streamer #(
    parameter int DATA_W     = 19,
    parameter int ADDR_W     = 11,
    parameter int MULT_W     = 16,
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 finish,
    input  logic [ADDR_W-1:0]    num_ch,
    input  logic [MULT_W-1:0]    mult,
    input  logic [4:0]           shift,
    output logic [ADDR_W-1:0]    read_pixel_index,
    input  logic [DATA_W-1:0]    data_in,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [8*LANES-1:0]   m_data,
    output logic [LANES-1:0]     m_keep,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done
);

    localparam int LANE_W = $clog2(LANES);
    localparam int BEAT_W = 8 * LANES;
    localparam int PROD_W = DATA_W + MULT_W;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 finish_prev_q;
    logic [ADDR_W-1:0]    num_ch_q, num_ch_d;
    logic [MULT_W-1:0]    mult_q, mult_d;
    logic [4:0]           shift_q, shift_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 rd_pend_q, rd_pend_d;
    logic [LANE_W-1:0]    rd_lane_q, rd_lane_d;
    logic                 rd_last_q, rd_last_d;
    logic [BEAT_W-1:0]    pack_data_q, pack_data_d;
    logic [LANES-1:0]     pack_keep_q, pack_keep_d;
    logic [CNT_W-1:0]     res_q, res_d;
    logic [BEAT_W-1:0]    fifo_data_q [FIFO_DEPTH];
    logic [BEAT_W-1:0]    fifo_data_d [FIFO_DEPTH];
    logic [LANES-1:0]     fifo_keep_q [FIFO_DEPTH];
    logic [LANES-1:0]     fifo_keep_d [FIFO_DEPTH];
    logic                 fifo_last_q [FIFO_DEPTH];
    logic                 fifo_last_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 start;
    logic [LANE_W-1:0]    addr_lane;
    logic                 last_addr;
    logic                 credit_ok;
    logic                 issue;
    logic                 push;
    logic                 pop;
    logic [PROD_W-1:0]    prod;
    logic [PROD_W:0]      round_add;
    logic [PROD_W:0]      sum;
    logic [PROD_W:0]      q_val;
    logic [7:0]           y;
    logic [BEAT_W-1:0]    merged_data;
    logic [LANES-1:0]     merged_keep;

    // Control strobes. A beat reserves its FIFO entry when its lane-0 read is
    // issued, so only lane-0 reads have to check credit; the remaining lanes
    // of a beat already own their slot.
    always_comb begin
        start     = (state_q == IDLE) && finish && !finish_prev_q;
        addr_lane = addr_q[LANE_W-1:0];
        last_addr = (addr_q == (num_ch_q - ADDR_W'(1)));
        credit_ok = ((count_q + res_q) < CNT_W'(FIFO_DEPTH));
        issue     = (state_q == READ) && ((addr_lane != '0) || credit_ok);
        push      = rd_pend_q && ((rd_lane_q == LANE_W'(LANES - 1)) || rd_last_q);
        pop       = m_valid && m_ready;
    end

    // Requantisation of the value returned for last cycle's read: widen the
    // sum by one bit so adding the rounding half cannot wrap.
    always_comb begin
        prod = PROD_W'(data_in) * PROD_W'(mult_q);
        if (shift_q != 5'd0) begin
            round_add = (PROD_W + 1)'(1) << (shift_q - 5'd1);
        end else begin
            round_add = '0;
        end
        sum   = {1'b0, prod} + round_add;
        q_val = sum >> shift_q;
        y     = (|q_val[PROD_W:8]) ? 8'hFF : q_val[7:0];
        merged_data = pack_data_q | (BEAT_W'(y) << {rd_lane_q, 3'b000});
        merged_keep = pack_keep_q | (LANES'(1) << rd_lane_q);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. DRAIN finishes on acceptance of the m_last beat,
    // which can only exist once every read has been packed and pushed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_ch == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (issue && last_addr) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Datapath next-state: run parameters, read address, pack register,
    // reservation count and beat FIFO.
    always_comb begin
        num_ch_d    = num_ch_q;
        mult_d      = mult_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        rd_pend_d   = issue;
        rd_lane_d   = rd_lane_q;
        rd_last_d   = rd_last_q;
        pack_data_d = pack_data_q;
        pack_keep_d = pack_keep_q;
        fifo_data_d = fifo_data_q;
        fifo_keep_d = fifo_keep_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        if (start) begin
            num_ch_d = num_ch;
            mult_d   = mult;
            shift_d  = shift;
            addr_d   = '0;
        end

        // The address parks on the final channel so the pooling block never
        // sees an out-of-range index.
        if (issue) begin
            rd_lane_d = addr_lane;
            rd_last_d = last_addr;
            if (!last_addr) begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end

        if (rd_pend_q) begin
            if (push) begin
                fifo_data_d[wr_ptr_q] = merged_data;
                fifo_keep_d[wr_ptr_q] = merged_keep;
                fifo_last_d[wr_ptr_q] = rd_last_q;
                wr_ptr_d    = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
                pack_data_d = '0;
                pack_keep_d = '0;
            end else begin
                pack_data_d = merged_data;
                pack_keep_d = merged_keep;
            end
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        res_d   = res_q + CNT_W'(issue && (addr_lane == '0)) - CNT_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Datapath registers. Reset abandons any run: partial beats and queued
    // beats are discarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            finish_prev_q <= 1'b0;
            num_ch_q      <= '0;
            mult_q        <= '0;
            shift_q       <= '0;
            addr_q        <= '0;
            rd_pend_q     <= 1'b0;
            rd_lane_q     <= '0;
            rd_last_q     <= 1'b0;
            pack_data_q   <= '0;
            pack_keep_q   <= '0;
            res_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_keep_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            finish_prev_q <= finish;
            num_ch_q      <= num_ch_d;
            mult_q        <= mult_d;
            shift_q       <= shift_d;
            addr_q        <= addr_d;
            rd_pend_q     <= rd_pend_d;
            rd_lane_q     <= rd_lane_d;
            rd_last_q     <= rd_last_d;
            pack_data_q   <= pack_data_d;
            pack_keep_q   <= pack_keep_d;
            res_q         <= res_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            fifo_data_q   <= fifo_data_d;
            fifo_keep_q   <= fifo_keep_d;
            fifo_last_q   <= fifo_last_d;
        end
    end

    // The credit scheme must make a push into a full FIFO impossible unless
    // the head leaves in the same cycle.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(push && !pop && (count_q == CNT_W'(FIFO_DEPTH))));
        end
    end

    // Stream outputs come straight from the FIFO head; lanes read as zero
    // whenever nothing is queued.
    always_comb begin
        read_pixel_index = addr_q;
        m_valid          = (count_q != '0);
        m_data           = m_valid ? fifo_data_q[rd_ptr_q] : '0;
        m_keep           = m_valid ? fifo_keep_q[rd_ptr_q] : '0;
        m_last           = m_valid ? fifo_last_q[rd_ptr_q] : 1'b0;
    end

endmodule

// File: tb/tb_gap_requant_streamer.sv
// ---------------------------------------------------------------------------
// tb_gap_requant_streamer
//
// Directed bench for gap_requant_streamer. A small memory model stands in
// for the pooling block (1-cycle read latency). A monitor on the falling
// edge logs every accepted beat and keeps running counts of done pulses,
// busy cycles and valid cycles, and flags any head change during a stall.
// ---------------------------------------------------------------------------
module tb_gap_requant_streamer;

    logic        clk;
    logic        reset_n;
    logic        finish;
    logic [10:0] num_ch;
    logic [15:0] mult;
    logic [4:0]  shift;
    logic [10:0] read_pixel_index;
    logic [18:0] data_in;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        busy;
    logic        done;

    logic [18:0] mem [16];

    logic [31:0] beat_data [$];
    logic [3:0]  beat_keep [$];
    logic        beat_last [$];

    int cyc         = 0;
    int accept_cyc  = 0;
    int done_cyc    = 0;
    int done_cnt    = 0;
    int busy_cnt    = 0;
    int valid_cnt   = 0;
    int stall_err   = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic [3:0]  prev_keep  = '0;
    logic        prev_last  = 1'b0;

    int tests_run = 0;
    int fail_cnt  = 0;

    gap_requant_streamer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .finish           (finish),
        .num_ch           (num_ch),
        .mult             (mult),
        .shift            (shift),
        .read_pixel_index (read_pixel_index),
        .data_in          (data_in),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_keep           (m_keep),
        .m_last           (m_last),
        .busy             (busy),
        .done             (done)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pooling-block model: data for the address seen at an edge appears
    // after that edge.
    always @(posedge clk) begin
        data_in <= mem[read_pixel_index[3:0]];
    end

    // Monitor, sampled mid-cycle so the handshake seen here is the one the
    // next rising edge acts upon.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset_n) begin
            if (m_valid && m_ready) begin
                beat_data.push_back(m_data);
                beat_keep.push_back(m_keep);
                beat_last.push_back(m_last);
                accept_cyc <= cyc;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (busy) begin
                busy_cnt <= busy_cnt + 1;
            end
            if (m_valid) begin
                valid_cnt <= valid_cnt + 1;
            end
            if (prev_stall && (!m_valid || (m_data !== prev_data) ||
                               (m_keep !== prev_keep) || (m_last !== prev_last))) begin
                stall_err <= stall_err + 1;
            end
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
            prev_keep  <= m_keep;
            prev_last  <= m_last;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Fill the pooling memory with a ramp (value = channel) or a constant.
    task automatic setMem(input bit ramp, input logic [18:0] value);
        for (int i = 0; i < 16; i++) begin
            mem[i] = ramp ? 19'(i) : value;
        end
    endtask

    // Present run parameters and raise finish, with finish low for at least
    // two edges beforehand so the rising edge is seen.
    task automatic applyStimulus(input logic [10:0] n, input logic [15:0] m,
                                 input logic [4:0] s);
        @(posedge clk); #1;
        finish = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        num_ch = n;
        mult   = m;
        shift  = s;
        finish = 1'b1;
    endtask

    // Wait, bounded, for the done pulse; optionally toggle m_ready at random
    // meanwhile. Drops finish and restores m_ready afterwards.
    task automatic waitDone(input string tag, input int budget, input bit rnd_ready);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (rnd_ready) begin
                m_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(tag, 32'(seen), 32'd1);
        @(posedge clk); #1;
        finish  = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        int d0;
        int b0;
        int v0;
        bit seen;

        reset_n = 1'b0;
        finish  = 1'b0;
        num_ch  = '0;
        mult    = '0;
        shift   = '0;
        m_ready = 1'b1;
        setMem(1'b1, '0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset m_valid", 32'(m_valid), 32'd0);
        checkOutput("reset busy/done", {30'd0, busy, done}, 32'd0);
        checkOutput("reset index", 32'(read_pixel_index), 32'd0);
        checkOutput("reset m_data", m_data, 32'd0);
        checkOutput("reset keep/last", {27'd0, m_keep, m_last}, 32'd0);
        reset_n = 1'b1;

        // Test 1: ramp, unity gain, 8 channels.
        base = beat_data.size();
        d0   = done_cnt;
        applyStimulus(11'd8, 16'd1, 5'd0);
        waitDone("t1 done", 100, 1'b0);
        checkOutput("t1 beats", 32'(beat_data.size() - base), 32'd2);
        checkOutput("t1 beat0 data", beat_data[base], 32'h03020100);
        checkOutput("t1 beat0 keep/last", {27'd0, beat_keep[base], beat_last[base]}, 32'h1E);
        checkOutput("t1 beat1 data", beat_data[base+1], 32'h07060504);
        checkOutput("t1 beat1 keep/last", {27'd0, beat_keep[base+1], beat_last[base+1]}, 32'h1F);
        checkOutput("t1 done latency", 32'(done_cyc - accept_cyc), 32'd1);
        checkOutput("t1 done pulses", 32'(done_cnt - d0), 32'd1);

        // Test 2: rounding shift, partial last beat. (500+8)>>4 = 31.
        setMem(1'b0, 19'd100);
        base = beat_data.size();
        applyStimulus(11'd6, 16'h0005, 5'd4);
        waitDone("t2 done", 100, 1'b0);
        checkOutput("t2 beats", 32'(beat_data.size() - base), 32'd2);
        checkOutput("t2 beat0 data", beat_data[base], 32'h1F1F1F1F);
        checkOutput("t2 beat0 keep/last", {27'd0, beat_keep[base], beat_last[base]}, 32'h1E);
        checkOutput("t2 beat1 data", beat_data[base+1], 32'h00001F1F);
        checkOutput("t2 beat1 keep/last", {27'd0, beat_keep[base+1], beat_last[base+1]}, 32'h07);

        // Test 3: saturation, zero input, and the largest shift on a
        // single-channel run (p/2^31 = 15.9997 rounds to 16).
        setMem(1'b0, 19'h7FFFF);
        base = beat_data.size();
        applyStimulus(11'd4, 16'hFFFF, 5'd0);
        waitDone("t3a done", 100, 1'b0);
        checkOutput("t3a sat data", beat_data[base], 32'hFFFFFFFF);
        checkOutput("t3a keep/last", {27'd0, beat_keep[base], beat_last[base]}, 32'h1F);
        setMem(1'b0, 19'd0);
        base = beat_data.size();
        applyStimulus(11'd4, 16'hFFFF, 5'd0);
        waitDone("t3b done", 100, 1'b0);
        checkOutput("t3b zero data", beat_data[base], 32'h00000000);
        setMem(1'b0, 19'h7FFFF);
        base = beat_data.size();
        applyStimulus(11'd1, 16'hFFFF, 5'd31);
        waitDone("t3c done", 100, 1'b0);
        checkOutput("t3c beats", 32'(beat_data.size() - base), 32'd1);
        checkOutput("t3c shift31 data", beat_data[base], 32'h00000010);
        checkOutput("t3c keep/last", {27'd0, beat_keep[base], beat_last[base]}, 32'h03);

        // Test 4: backpressure. With the output stalled only two beats fit,
        // so reads stop with the address parked on channel 8.
        setMem(1'b1, '0);
        base    = beat_data.size();
        m_ready = 1'b0;
        applyStimulus(11'd16, 16'd1, 5'd0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("t4 stalled index", 32'(read_pixel_index), 32'd8);
        checkOutput("t4 stalled valid", 32'(m_valid), 32'd1);
        checkOutput("t4 stalled head", m_data, 32'h03020100);
        waitDone("t4 done", 400, 1'b1);
        checkOutput("t4 beats", 32'(beat_data.size() - base), 32'd4);
        checkOutput("t4 beat0", beat_data[base], 32'h03020100);
        checkOutput("t4 beat1", beat_data[base+1], 32'h07060504);
        checkOutput("t4 beat2", beat_data[base+2], 32'h0B0A0908);
        checkOutput("t4 beat3", beat_data[base+3], 32'h0F0E0D0C);
        checkOutput("t4 last flags", {28'd0, beat_last[base], beat_last[base+1],
                                      beat_last[base+2], beat_last[base+3]}, 32'h1);
        checkOutput("t4 stall stability", 32'(stall_err), 32'd0);

        // Test 5: empty run.
        base = beat_data.size();
        d0   = done_cnt;
        b0   = busy_cnt;
        v0   = valid_cnt;
        applyStimulus(11'd0, 16'd1, 5'd0);
        waitDone("t5 done", 20, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5 done pulses", 32'(done_cnt - d0), 32'd1);
        checkOutput("t5 busy cycles", 32'(busy_cnt - b0), 32'd1);
        checkOutput("t5 valid cycles", 32'(valid_cnt - v0), 32'd0);

        // Test 6: reset after the first beat is accepted, finish held high.
        setMem(1'b1, '0);
        applyStimulus(11'd8, 16'd1, 5'd0);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("t6 first beat seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        checkOutput("t6 reset valid/busy/done", {29'd0, m_valid, busy, done}, 32'd0);
        checkOutput("t6 reset data", m_data, 32'd0);
        checkOutput("t6 reset index", 32'(read_pixel_index), 32'd0);
        checkOutput("t6 reset keep/last", {27'd0, m_keep, m_last}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        base    = beat_data.size();
        reset_n = 1'b1;
        waitDone("t6 rerun done", 100, 1'b0);
        checkOutput("t6 rerun beats", 32'(beat_data.size() - base), 32'd2);
        checkOutput("t6 rerun beat0", beat_data[base], 32'h03020100);
        checkOutput("t6 rerun beat1", beat_data[base+1], 32'h07060504);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
